// File: rtl/rgb_sram_fetch_pkg.sv
// Shared types and frame constants for the VGA-side RGB fetch path.
package rgb_sram_fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH_IDLE,
    S_FETCH_RUN,
    S_FETCH_DONE
  } fetch_state_t;

  localparam int unsigned VIEW_WIDTH  = 320;
  localparam int unsigned VIEW_HEIGHT = 240;
  localparam int unsigned RGB_WORDS   = 115200;
  localparam int unsigned RGB_BASE    = 146944;

endpackage

// File: rtl/rgb_sram_fetch_word_fifo.sv
// Synchronous 16-bit word FIFO exposing the two oldest entries; pops 0, 1 or 2 words per cycle.
module rgb_sram_fetch_word_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [15:0]                push_data,
  input  logic [1:0]                 pop_num,
  output logic [15:0]                head0,
  output logic [15:0]                head1,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_num);
      count  <= count + CW'(push) - CW'(pop_num);
    end
  end

  always_comb begin
    head0 = mem[rd_ptr];
    head1 = mem[rd_ptr + AW'(1)];
  end

endmodule

// File: rtl/rgb_sram_fetch.sv
// Prefetches packed RGB words from SRAM into a small FIFO and unpacks two pixels per three words.
module rgb_sram_fetch
  import rgb_sram_fetch_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR    = 18'(RGB_BASE),
  parameter int unsigned NUM_WORDS    = RGB_WORDS,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Frame_start,
  input  logic        Pixel_req,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        Pixel_valid,
  output logic [7:0]  Pixel_R,
  output logic [7:0]  Pixel_G,
  output logic [7:0]  Pixel_B,
  output logic        Underflow,
  output logic        Frame_done
);

  localparam int unsigned IssW = $clog2(NUM_WORDS + 1);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [IssW-1:0] NumC   = IssW'(NUM_WORDS);
  localparam logic [CntW:0]   DepthC = (CntW + 1)'(FIFO_DEPTH);

  fetch_state_t            state;
  logic [IssW-1:0]         issued;
  logic [READ_LATENCY-1:0] vsr;
  logic [CntW-1:0]         in_flight;
  logic [CntW-1:0]         fifo_count;
  logic [15:0]             head0;
  logic [15:0]             head1;
  logic                    phase;
  logic [7:0]              r1_hold;
  logic                    issue;
  logic                    push;
  logic                    starved;
  logic                    served;
  logic [1:0]              pop_num;

  assign SRAM_we_n = 1'b1;

  // Reserve FIFO space for reads still in the SRAM pipeline so a push never overflows.
  always_comb begin
    issue   = (state == S_FETCH_RUN) && !Frame_start &&
              (({1'b0, fifo_count} + {1'b0, in_flight}) < DepthC) && (issued < NumC);
    push    = vsr[READ_LATENCY-1] && !Frame_start;
    starved = fifo_count < CntW'(2);
    served  = Pixel_req && !Frame_start && !starved;
    pop_num = served ? (phase ? 2'd2 : 2'd1) : 2'd0;
  end

  rgb_sram_fetch_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (Clock),
    .reset    (Reset),
    .flush    (Frame_start),
    .push     (push),
    .push_data(SRAM_read_data),
    .pop_num  (pop_num),
    .head0    (head0),
    .head1    (head1),
    .count    (fifo_count)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_FETCH_IDLE;
      SRAM_address <= BASE_ADDR;
      issued       <= '0;
      vsr          <= '0;
      in_flight    <= '0;
      phase        <= 1'b0;
      r1_hold      <= '0;
      Pixel_valid  <= 1'b0;
      Pixel_R      <= '0;
      Pixel_G      <= '0;
      Pixel_B      <= '0;
      Underflow    <= 1'b0;
      Frame_done   <= 1'b0;
    end else if (Frame_start) begin
      state        <= S_FETCH_RUN;
      SRAM_address <= BASE_ADDR;
      issued       <= '0;
      vsr          <= '0;
      in_flight    <= '0;
      phase        <= 1'b0;
      Pixel_valid  <= 1'b0;
      Underflow    <= 1'b0;
      Frame_done   <= 1'b0;
    end else begin
      Pixel_valid <= 1'b0;
      vsr         <= (vsr << 1) | READ_LATENCY'(issue);
      in_flight   <= in_flight + CntW'(issue) - CntW'(push);
      if (issue) begin
        SRAM_address <= SRAM_address + 18'd1;
        issued       <= issued + IssW'(1);
        if (issued == NumC - IssW'(1)) begin
          state      <= S_FETCH_DONE;
          Frame_done <= 1'b1;
        end
      end
      if (Pixel_req) begin
        Pixel_valid <= 1'b1;
        if (starved) begin
          Pixel_R   <= '0;
          Pixel_G   <= '0;
          Pixel_B   <= '0;
          Underflow <= 1'b1;
        end else if (!phase) begin
          Pixel_R <= head0[15:8];
          Pixel_G <= head0[7:0];
          Pixel_B <= head1[15:8];
          r1_hold <= head1[7:0];
          phase   <= 1'b1;
        end else begin
          // head0 is w1 here; its low byte was captured on the previous pixel.
          Pixel_R <= r1_hold;
          Pixel_G <= head1[15:8];
          Pixel_B <= head1[7:0];
          phase   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_sram_fetch.sv
// Self-checking bench for rgb_sram_fetch: SRAM model, byte-stream pixel model and directed tests.
module tb_rgb_sram_fetch;

  localparam logic [17:0] Base    = 18'd146944;
  localparam int unsigned TbWords = 3000;
  localparam int unsigned TbPix   = TbWords * 2 / 3;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Frame_start;
  logic        Pixel_req;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        Pixel_valid;
  logic [7:0]  Pixel_R;
  logic [7:0]  Pixel_G;
  logic [7:0]  Pixel_B;
  logic        Underflow;
  logic        Frame_done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [TbWords];
  logic [15:0] rd1 = '0;
  logic [15:0] rd2 = '0;

  always #10 Clock = ~Clock;

  rgb_sram_fetch #(
    .BASE_ADDR   (Base),
    .NUM_WORDS   (TbWords),
    .FIFO_DEPTH  (8),
    .READ_LATENCY(2)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Frame_start   (Frame_start),
    .Pixel_req     (Pixel_req),
    .SRAM_address  (SRAM_address),
    .SRAM_we_n     (SRAM_we_n),
    .SRAM_read_data(SRAM_read_data),
    .Pixel_valid   (Pixel_valid),
    .Pixel_R       (Pixel_R),
    .Pixel_G       (Pixel_G),
    .Pixel_B       (Pixel_B),
    .Underflow     (Underflow),
    .Frame_done    (Frame_done)
  );

  // Two-cycle SRAM: address seen at one edge returns data two edges later.
  always @(posedge Clock) begin
    if (int'(SRAM_address) >= int'(Base) && int'(SRAM_address) < int'(Base) + TbWords)
      rd1 <= mem[int'(SRAM_address) - int'(Base)];
    else
      rd1 <= 16'hDEAD;
    rd2 <= rd1;
  end
  assign SRAM_read_data = rd2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int k);
    logic [15:0] w;
    w = mem[k / 2];
    return (k % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [23:0] pix(input int n);
    return {byte_at(3 * n), byte_at(3 * n + 1), byte_at(3 * n + 2)};
  endfunction

  // Highest word index that must already be in the FIFO to serve pixel n.
  function automatic int need(input int n);
    return (n % 2 == 0) ? (3 * n / 2 + 1) : ((3 * n + 1) / 2);
  endfunction

  // Model: word j reaches the FIFO in cycle fs+4+j; a request is served once its words are there.
  int          cyc = 0;
  int          fs_cyc = 0;
  int          pix_n = 0;
  logic        active = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_uf = 1'b0;
  logic [23:0] exp_rgb = '0;

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (Reset) begin
      active    <= 1'b0;
      pix_n     <= 0;
      exp_valid <= 1'b0;
      exp_uf    <= 1'b0;
      exp_rgb   <= '0;
    end else if (Frame_start) begin
      active    <= 1'b1;
      fs_cyc    <= cyc;
      pix_n     <= 0;
      exp_valid <= 1'b0;
      exp_uf    <= 1'b0;
    end else if (Pixel_req) begin
      exp_valid <= 1'b1;
      if (active && need(pix_n) < TbWords && cyc >= fs_cyc + 4 + need(pix_n)) begin
        exp_rgb <= pix(pix_n);
        pix_n   <= pix_n + 1;
      end else begin
        exp_rgb <= '0;
        exp_uf  <= 1'b1;
      end
    end else begin
      exp_valid <= 1'b0;
    end
  end

  always @(negedge Clock) begin
    if (!Reset) begin
      check("pixel_valid", 32'(Pixel_valid), 32'(exp_valid));
      check("underflow", 32'(Underflow), 32'(exp_uf));
      check("pixel_rgb", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'(exp_rgb));
    end
  end

  // Read issues are recovered from address steps; a Frame_start reload is not an issue.
  logic [17:0] prev_addr = '0;
  logic [17:0] last_iss = '0;
  int          iss_cnt = 0;
  logic        fs_seen = 1'b0;

  always @(posedge Clock) fs_seen <= Frame_start;

  always @(negedge Clock) begin
    prev_addr <= SRAM_address;
    if (Reset || fs_seen) begin
      iss_cnt <= 0;
    end else if (SRAM_address != prev_addr) begin
      iss_cnt  <= iss_cnt + 1;
      last_iss <= prev_addr;
    end
  end

  task automatic step(input logic fs, input logic req);
    Frame_start = fs;
    Pixel_req   = req;
    @(negedge Clock);
    Frame_start = 1'b0;
    Pixel_req   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < TbWords; i++) mem[i] = 16'(i * 40503 + 12345);
    mem[0] = 16'h1122;
    mem[1] = 16'h3344;
    mem[2] = 16'h5566;
    Reset       = 1'b1;
    Frame_start = 1'b0;
    Pixel_req   = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset_addr", 32'(SRAM_address), 32'(Base));
    check("reset_we_n", 32'(SRAM_we_n), 32'd1);
    check("reset_valid", 32'(Pixel_valid), 32'd0);
    check("reset_rgb", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'd0);
    check("reset_underflow", 32'(Underflow), 32'd0);
    check("reset_done", 32'(Frame_done), 32'd0);
    Reset = 1'b0;
    idle(2);

    // Request while idle with an empty FIFO.
    step(1'b0, 1'b1);
    check("idle_req_valid", 32'(Pixel_valid), 32'd1);
    check("idle_req_underflow", 32'(Underflow), 32'd1);

    // First two pixels of a frame.
    step(1'b1, 1'b0);
    check("fs_clears_underflow", 32'(Underflow), 32'd0);
    check("fs_first_addr", 32'(SRAM_address), 32'(Base));
    idle(5);
    step(1'b0, 1'b1);
    check("px0_valid", 32'(Pixel_valid), 32'd1);
    check("px0_rgb", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'h112233);
    step(1'b0, 1'b0);
    check("px0_hold", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'h112233);
    step(1'b0, 1'b1);
    check("px1_rgb", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'h445566);
    check("px1_underflow", 32'(Underflow), 32'd0);

    // Request one cycle after Frame_start, then a served one eight cycles later.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("early_valid", 32'(Pixel_valid), 32'd1);
    check("early_rgb", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'h000000);
    check("early_underflow", 32'(Underflow), 32'd1);
    idle(7);
    step(1'b0, 1'b1);
    check("late_rgb", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'h112233);
    check("late_underflow_sticky", 32'(Underflow), 32'd1);

    // No consumption: fetch stops at FIFO depth.
    step(1'b1, 1'b0);
    idle(50);
    check("fill_addr", 32'(SRAM_address), 32'(Base) + 32'd8);
    check("fill_issues", 32'(iss_cnt), 32'd8);
    check("fill_count", 32'(dut.u_fifo.count), 32'd8);

    // Frame_start wins over a coincident request.
    step(1'b1, 1'b1);
    check("fs_req_valid", 32'(Pixel_valid), 32'd0);
    check("fs_req_addr0", 32'(SRAM_address), 32'(Base));
    step(1'b0, 1'b0);
    check("fs_req_addr1", 32'(SRAM_address), 32'(Base) + 32'd1);

    // Restart after 1000 served pixels.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(4);
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    step(1'b1, 1'b0);
    check("restart_underflow", 32'(Underflow), 32'd0);
    check("restart_done", 32'(Frame_done), 32'd0);
    idle(5);
    step(1'b0, 1'b1);
    check("restart_rgb", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'h112233);

    // Full (shortened) frame.
    step(1'b1, 1'b0);
    idle(5);
    for (int i = 0; i < int'(TbPix); i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    idle(20);
    check("frame_done", 32'(Frame_done), 32'd1);
    check("frame_underflow", 32'(Underflow), 32'd0);
    check("frame_issues", 32'(iss_cnt), 32'(TbWords));
    check("frame_last_addr", 32'(last_iss), 32'(Base) + 32'(TbWords) - 32'd1);
    check("frame_addr_hold", 32'(SRAM_address), 32'(Base) + 32'(TbWords));
    step(1'b0, 1'b1);
    check("past_end_underflow", 32'(Underflow), 32'd1);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
